// File: rtl/grid_pkg.sv
// Shared types, colours and grid defaults for the board cursor controller.
// Colours are packed as {R, G, B}, one byte each.
package grid_pkg;

  localparam int GRID_W_DEF = 8;
  localparam int GRID_H_DEF = 8;

  localparam logic [23:0] RGB_EMPTY  = 24'h53565B;
  localparam logic [23:0] RGB_CURSOR = 24'hFFFFFF;
  localparam logic [23:0] RGB_P1     = 24'hD02020;
  localparam logic [23:0] RGB_P2     = 24'hF0D020;

  typedef enum logic [1:0] {
    OWN_EMPTY = 2'd0,
    OWN_P1    = 2'd1,
    OWN_P2    = 2'd2
  } owner_t;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_PAINT   = 3'd1,
    ST_IDLE    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_PLACE   = 3'd4
  } state_t;

  // An owned cell always shows its owner; the cursor only shows on empty cells.
  function automatic logic [23:0] cell_rgb(input owner_t own, input logic under_cursor);
    case (own)
      OWN_P1:  cell_rgb = RGB_P1;
      OWN_P2:  cell_rgb = RGB_P2;
      default: cell_rgb = under_cursor ? RGB_CURSOR : RGB_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pulse_edge.sv
// One-bit rising-edge detector; the history flop updates every cycle so a
// held level yields exactly one pulse.
module pulse_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Turns button edges into renderer cell writes while owning the board state,
// cursor position and turn order. All outputs are registered.
module grid_cursor_ctrl
  import grid_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  output logic       wr_enable,
  output logic [3:0] posX,
  output logic [3:0] posY,
  output logic [7:0] wr_r,
  output logic [7:0] wr_g,
  output logic [7:0] wr_b,
  output logic       cur_player,
  output logic       busy,
  output logic       board_full,
  output logic [2:0] dbg_state
);

  localparam int         CELLS    = GRID_W * GRID_H;
  localparam int         CW       = $clog2(CELLS);
  localparam logic [6:0] FULL_CNT = 7'(CELLS);

  logic w_e_up, w_e_down, w_e_left, w_e_right, w_e_place;

  pulse_edge u_edge_up    (.i_clk(clk), .i_rst(rst), .i_level(btn_up),    .o_pulse(w_e_up));
  pulse_edge u_edge_down  (.i_clk(clk), .i_rst(rst), .i_level(btn_down),  .o_pulse(w_e_down));
  pulse_edge u_edge_left  (.i_clk(clk), .i_rst(rst), .i_level(btn_left),  .o_pulse(w_e_left));
  pulse_edge u_edge_right (.i_clk(clk), .i_rst(rst), .i_level(btn_right), .o_pulse(w_e_right));
  pulse_edge u_edge_place (.i_clk(clk), .i_rst(rst), .i_level(btn_place), .o_pulse(w_e_place));

  state_t      r_state;
  logic [3:0]  r_cur_x, r_cur_y;
  logic        r_init_done;
  logic [6:0]  r_count;
  logic        r_full;
  logic        r_player;
  logic        r_wr_en;
  logic [3:0]  r_pos_x, r_pos_y;
  logic [23:0] r_rgb;
  logic        r_busy;
  owner_t      r_occ [CELLS];

  logic [CW-1:0] w_cur_idx;
  owner_t        w_cur_own;

  assign w_cur_idx = CW'(int'(r_cur_y) * GRID_W + int'(r_cur_x));
  assign w_cur_own = r_occ[w_cur_idx];

  state_t      w_state_nxt;
  logic        w_wr_en;
  logic [3:0]  w_wr_x, w_wr_y;
  logic [23:0] w_wr_rgb;
  logic [3:0]  w_cur_x_nxt, w_cur_y_nxt;
  logic        w_init_done_nxt;
  logic        w_occ_we;
  owner_t      w_occ_val;
  logic        w_place;

  // A state's write is registered on the edge that enters it, so the strobe
  // is on the outputs while the FSM sits in that state (INIT lags by one).
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_en         = 1'b0;
    w_wr_x          = r_cur_x;
    w_wr_y          = r_cur_y;
    w_wr_rgb        = 24'h0;
    w_cur_x_nxt     = r_cur_x;
    w_cur_y_nxt     = r_cur_y;
    w_init_done_nxt = r_init_done;
    w_occ_we        = 1'b0;
    w_occ_val       = OWN_EMPTY;
    w_place         = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_wr_en = 1'b1;
        if (!r_init_done) begin
          // The cursor doubles as the raster scan pointer and ends on (0,0).
          w_wr_rgb = RGB_EMPTY;
          w_occ_we = 1'b1;
          if (r_cur_x == 4'(GRID_W - 1)) begin
            w_cur_x_nxt = 4'd0;
            if (r_cur_y == 4'(GRID_H - 1)) begin
              w_cur_y_nxt     = 4'd0;
              w_init_done_nxt = 1'b1;
            end else begin
              w_cur_y_nxt = r_cur_y + 4'd1;
            end
          end else begin
            w_cur_x_nxt = r_cur_x + 4'd1;
          end
        end else begin
          w_wr_x          = 4'd0;
          w_wr_y          = 4'd0;
          w_wr_rgb        = RGB_CURSOR;
          w_init_done_nxt = 1'b0;
          w_state_nxt     = ST_PAINT;
        end
      end
      ST_IDLE: begin
        if (w_e_place) begin
          if (w_cur_own == OWN_EMPTY && !r_full) begin
            w_place     = 1'b1;
            w_occ_we    = 1'b1;
            w_occ_val   = r_player ? OWN_P2 : OWN_P1;
            w_wr_en     = 1'b1;
            w_wr_rgb    = r_player ? RGB_P2 : RGB_P1;
            w_state_nxt = ST_PLACE;
          end
        end else if (w_e_up || w_e_down || w_e_left || w_e_right) begin
          w_wr_en     = 1'b1;
          w_wr_rgb    = cell_rgb(w_cur_own, 1'b0);
          w_state_nxt = ST_RESTORE;
          if (w_e_up)
            w_cur_y_nxt = (r_cur_y == 4'd0) ? 4'(GRID_H - 1) : r_cur_y - 4'd1;
          else if (w_e_down)
            w_cur_y_nxt = (r_cur_y == 4'(GRID_H - 1)) ? 4'd0 : r_cur_y + 4'd1;
          else if (w_e_left)
            w_cur_x_nxt = (r_cur_x == 4'd0) ? 4'(GRID_W - 1) : r_cur_x - 4'd1;
          else
            w_cur_x_nxt = (r_cur_x == 4'(GRID_W - 1)) ? 4'd0 : r_cur_x + 4'd1;
        end
      end
      ST_RESTORE: begin
        w_wr_en     = 1'b1;
        w_wr_rgb    = cell_rgb(w_cur_own, 1'b1);
        w_state_nxt = ST_PAINT;
      end
      ST_PAINT: w_state_nxt = ST_IDLE;
      ST_PLACE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cur_x     <= 4'd0;
      r_cur_y     <= 4'd0;
      r_init_done <= 1'b0;
      r_count     <= 7'd0;
      r_full      <= 1'b0;
      r_player    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_pos_x     <= 4'd0;
      r_pos_y     <= 4'd0;
      r_rgb       <= 24'h0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_x     <= w_cur_x_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_init_done <= w_init_done_nxt;
      r_wr_en     <= w_wr_en;
      r_pos_x     <= w_wr_x;
      r_pos_y     <= w_wr_y;
      r_rgb       <= w_wr_rgb;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_place) begin
        r_count  <= r_count + 7'd1;
        r_full   <= (r_count + 7'd1 == FULL_CNT);
        r_player <= ~r_player;
      end
    end
  end

  // Occupancy needs no reset: INIT rewrites every cell before anything reads it.
  always_ff @(posedge clk) begin
    if (w_occ_we) r_occ[w_cur_idx] <= w_occ_val;
  end

  assign wr_enable  = r_wr_en;
  assign posX       = r_pos_x;
  assign posY       = r_pos_y;
  assign wr_r       = r_rgb[23:16];
  assign wr_g       = r_rgb[15:8];
  assign wr_b       = r_rgb[7:0];
  assign cur_player = r_player;
  assign busy       = r_busy;
  assign board_full = r_full;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl: a negedge write monitor checks every
// strobe (cell, colour and cycle) against an expected queue fed by the tests.
module tb_grid_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
  logic       wr_enable;
  logic [3:0] posX, posY;
  logic [7:0] wr_r, wr_g, wr_b;
  logic       cur_player, busy, board_full;
  logic [2:0] dbg_state;

  grid_cursor_ctrl #(.GRID_W(8), .GRID_H(8)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_place(btn_place),
    .wr_enable(wr_enable), .posX(posX), .posY(posY),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .cur_player(cur_player), .busy(busy), .board_full(board_full),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_unexp = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] got, e;
    int          ec;
    if (rst === 1'b0 && wr_enable === 1'b1) begin
      got = {posX, posY, wr_r, wr_g, wr_b};
      if (exp_q.size() == 0) begin
        n_unexp++;
        $display("unexpected write %0h at cycle %0d", got, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("wr_data", got, e);
        check("wr_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  task automatic phase_end();
    check("wr_missing", 32'(exp_q.size()), 0);
    check("wr_unexpected", 32'(n_unexp), 0);
  endtask

  // ---------------- reference model ----------------
  int   own [8][8];
  int   mx, my, placed;
  logic mplayer;

  function automatic logic [23:0] exp_rgb(input int o, input bit cur);
    if (o == 1)   return 24'hD02020;
    if (o == 2)   return 24'hF0D020;
    if (cur)      return 24'hFFFFFF;
    return 24'h53565B;
  endfunction

  task automatic push_wr(input int x, input int y, input logic [23:0] rgb, input int c);
    exp_q.push_back({4'(x), 4'(y), rgb});
    exp_cyc_q.push_back(c);
  endtask

  task automatic model_clear();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) own[y][x] = 0;
    mx = 0; my = 0; placed = 0; mplayer = 1'b0;
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge: raise the buttons in b for exactly one cycle.
  task automatic press(input logic [4:0] b, output int c);
    c = cyc;
    {btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk);
    {btn_place, btn_up, btn_down, btn_left, btn_right} = 5'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_c);
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    check(tag, 32'(cyc), 32'(exp_c));
  endtask

  task automatic check_reset_vals();
    check("rst_wr_enable", 32'(wr_enable), 0);
    check("rst_pos", {posX, posY}, 0);
    check("rst_rgb", {wr_r, wr_g, wr_b}, 0);
    check("rst_player", 32'(cur_player), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_full", 32'(board_full), 0);
    check("rst_state", 32'(dbg_state), 0);
  endtask

  task automatic start_init(output int base);
    model_clear();
    base = cyc;
    for (int i = 0; i < 64; i++) push_wr(i % 8, i / 8, 24'h53565B, base + i + 1);
    push_wr(0, 0, 24'hFFFFFF, base + 65);
    rst = 1'b0;
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right
  task automatic move(input int dir);
    int c, nx, ny;
    logic [4:0] b;
    nx = mx; ny = my;
    case (dir)
      0:       begin ny = (my == 0) ? 7 : my - 1; b = 5'b01000; end
      1:       begin ny = (my == 7) ? 0 : my + 1; b = 5'b00100; end
      2:       begin nx = (mx == 0) ? 7 : mx - 1; b = 5'b00010; end
      default: begin nx = (mx == 7) ? 0 : mx + 1; b = 5'b00001; end
    endcase
    push_wr(mx, my, exp_rgb(own[my][mx], 1'b0), cyc + 1);
    push_wr(nx, ny, exp_rgb(own[ny][nx], 1'b1), cyc + 2);
    mx = nx; my = ny;
    press(b, c);
    wait_idle("move_idle", c + 3);
  endtask

  task automatic place();
    int c;
    bit ok;
    ok = (own[my][mx] == 0) && (placed < 64);
    if (ok) begin
      push_wr(mx, my, mplayer ? 24'hF0D020 : 24'hD02020, cyc + 1);
      own[my][mx] = mplayer ? 2 : 1;
      mplayer = ~mplayer;
      placed++;
    end
    press(5'b10000, c);
    check("place_player", 32'(cur_player), 32'(mplayer));
    if (ok) wait_idle("place_idle", c + 2);
    else    check("place_rej_busy", 32'(busy), 0);
  endtask

  task automatic goto_cell(input int x, input int y);
    while (mx != x) move(3);
    while (my != y) move(1);
  endtask

  // ---------------- tests ----------------
  initial begin
    int base, c;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Power-up INIT: 64 empty writes, cursor paint, idle on cycle 66.
    start_init(base);
    wait_idle("init_idle", base + 66);
    phase_end();

    // Move right, then wrap left twice and up to (7,7).
    move(3);
    move(2);
    move(2);
    check("wrap_left_x", 32'(posX), 7);
    move(0);
    check("wrap_up_pos", {posX, posY}, {4'd7, 4'd7});
    phase_end();

    // Place at (3,4), then a rejected second place on the same cell.
    goto_cell(3, 4);
    place();
    check("place1_player", 32'(cur_player), 1);
    place();
    check("place2_player", 32'(cur_player), 1);
    phase_end();

    // Place and right together: only the place happens.
    move(3);
    push_wr(4, 4, 24'hF0D020, cyc + 1);
    own[4][4] = 2; mplayer = 1'b0; placed++;
    press(5'b10001, c);
    check("simul_player", 32'(cur_player), 0);
    wait_idle("simul_idle", c + 2);
    move(3);
    phase_end();

    // A new edge on another button while busy is dropped.
    push_wr(5, 4, 24'h53565B, cyc + 1);
    push_wr(6, 4, 24'hFFFFFF, cyc + 2);
    mx = 6;
    press(5'b00001, c);
    press(5'b00100, base);
    wait_idle("busy_drop_idle", c + 3);
    move(1);
    phase_end();

    // Fill the board, then confirm full behaviour.
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (own[y][x] == 0) begin
          goto_cell(x, y);
          if (placed == 63) check("full_before_last", 32'(board_full), 0);
          place();
        end
      end
    end
    check("board_full", 32'(board_full), 1);
    place();
    move(3);
    check("full_stays", 32'(board_full), 1);
    phase_end();

    // Reset during INIT write 30, then a clean restart with a cleared board.
    rst = 1'b1;
    @(negedge clk);
    start_init(base);
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_vals();
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    start_init(base);
    wait_idle("reinit_idle", base + 66);
    phase_end();
    move(3);
    check("reinit_player", 32'(cur_player), 0);
    phase_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_cursor_ctrl.md
# grid_cursor_ctrl

Upstream controller for the 8x8 VGA board renderer. It converts player button inputs into cell-write transactions (`wr_enable`, `posX`/`posY`, RGB). It keeps the authoritative cell-ownership state, the cursor position and the turn order. The renderer stores and displays the colours; this block decides what every cell shows.

## Interface
- `GRID_W`, default 8: columns; cursor X range is 0..GRID_W-1.
- `GRID_H`, default 8: rows; cursor Y range is 0..GRID_H-1.
- `clk` in 1: single clock (VGA pixel clock domain).
- `rst` in 1: **asynchronous, active-high** reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_place` in 1 each: debounced, synchronous levels. Rising edges are detected internally.
- `wr_enable` out 1: one-cycle write strobe to the renderer.
- `posX` out 4: target column of the write.
- `posY` out 4: target row of the write.
- `wr_r`, `wr_g`, `wr_b` out 8 each: colour of the write.
- `cur_player` out 1: 0 = player 1, 1 = player 2.
- `busy` out 1: FSM is not in IDLE; button edges are dropped.
- `board_full` out 1: all GRID_W*GRID_H cells are owned.

## Operation
- **Occupancy:** a GRID_W x GRID_H array of 2-bit owner codes: EMPTY=0, P1=1, P2=2. A 7-bit piece counter counts owned cells.
- **Cell colour rule:**
  - Owned cell: owner colour.
  - Empty cell under the cursor: CURSOR colour.
  - Any other empty cell: EMPTY colour.
- **States:** INIT, PAINT, IDLE, RESTORE, PLACE.
- **INIT (entered on reset):**
  - Writes EMPTY colour to every cell, one write per cycle, in raster order (x fastest).
  - Clears occupancy.
  - Then moves the cursor to (0,0) and goes to PAINT.
- **IDLE:** accepts at most one button edge per cycle. Priority is place > up > down > left > right; other simultaneous edges are discarded.
- **Move:**
  - Latch the new cursor position.
  - RESTORE writes the old cell using the colour rule with the cursor absent.
  - PAINT writes the new cell using the colour rule.
  - Return to IDLE.
- **Wrap-around:**
  - left at x=0 goes to x=GRID_W-1; right at x=GRID_W-1 goes to 0.
  - up at y=0 goes to y=GRID_H-1; down at y=GRID_H-1 goes to 0.
- **Place:**
  - Only when the cursor cell is EMPTY and `board_full`=0.
  - Set owner = cur_player+1, increment the counter, toggle `cur_player`.
  - PLACE writes the owner colour, then returns to IDLE.
- **Rejected place:** on an occupied cell or when full, no write, no toggle, FSM stays in IDLE.
- **Full board:** `board_full` asserts when the counter reaches GRID_W*GRID_H. Moves still work; places are ignored.
- **Edges while busy:** dropped, not queued. The edge-detect register still updates, so a held button produces no later edge.

## Timing
- **Reset values:**
  - `wr_enable`=0, `posX`=`posY`=0, RGB=0.
  - `cur_player`=0, `busy`=1, `board_full`=0.
  - State=INIT, cursor=(0,0), counter=0, edge-detect registers=0.
- **Write timing:** `posX`, `posY` and RGB are valid in the same cycle as `wr_enable`. The renderer latches them on that rising edge. All outputs are registered.
- **INIT:**
  - Starts on the first clock after reset deassertion.
  - 64 writes in consecutive cycles, then 1 PAINT write.
  - IDLE (`busy`=0) on cycle 66.
- **Move:** edge seen in IDLE at cycle N; RESTORE write at N+1; PAINT write at N+2; `busy`=0 from N+3.
- **Place:** edge at N; PLACE write at N+1; `cur_player` toggles at N+1; `busy`=0 from N+2.
- **Reset mid-operation:** immediately aborts any sequence. INIT restarts and fully clears the board.

## Structure
- Package `grid_pkg`:
  - Colours: EMPTY 53/56/5B, CURSOR FF/FF/FF, P1 D0/20/20, P2 F0/D0/20.
  - Owner-code enum and state enum.
  - GRID defaults.
- Sub-module `pulse_edge`: a one-bit registered rising-edge detector with async reset, instantiated five times.

## Test plan
- **Reset:** release `rst` → 64 strobes in raster order with RGB 53/56/5B, then (0,0) FF/FF/FF, then `busy`=0 on cycle 66.
- **Move right:** from (0,0) pulse `btn_right` → (0,0) 53/56/5B, then (1,0) FF/FF/FF on consecutive cycles.
- **Wrap:** at (0,0) pulse `btn_left` then `btn_up` → cursor ends at (7,7); final PAINT write is to (7,7).
- **Place:**
  - At (3,4) pulse `btn_place` → single write (3,4) D0/20/20 and `cur_player`=1.
  - Second place at (3,4) → no strobe, `cur_player` stays 1.
- **Simultaneous edges:** `btn_place` and `btn_right` rise in the same cycle → only the place write occurs; cursor unchanged. Edges during `busy` produce no writes.
- **Fill and reset:**
  - Fill all 64 cells → `board_full`=1 and a further place gives no strobe.
  - Assert `rst` during INIT write 30 → outputs return to reset values and INIT restarts at (0,0).
